// File: rtl/seg_bcd_counter_mux.sv
// Multi-digit BCD up/down counter with prescaler, checked load and scanned 7-segment driver.
// Latency: count/tc/load_err update on the edge after a tick or load; seg/an lag the scan index by 1 cycle.
// No backpressure: en freezes prescaler and counter only; scanning always runs.
module seg_bcd_counter_mux #(
  parameter int PRESCALE    = 100000000,
  parameter int REFRESH_DIV = 100000,
  parameter int DIGITS      = 4,
  parameter int MAX_VALUE   = 9999,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  load_err,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = $clog2(DIGITS);
  localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  // Decimal to packed BCD, evaluated only at elaboration for the wrap constant.
  function automatic logic [W-1:0] dec_to_bcd(input int v);
    logic [W-1:0] b;
    int           r;
    b = '0;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  localparam logic [W-1:0] MAX_BCD = dec_to_bcd(MAX_VALUE);

  // Active-low {g,f,e,d,c,b,a} glyphs; non-decimal nibbles render dark.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  logic [PW-1:0]    pcnt;
  logic [SW-1:0]    scnt;
  logic [IDX_W-1:0] idx;
  logic             tick;
  logic             load_ok;
  logic [W-1:0]     inc_val;
  logic [W-1:0]     dec_val;
  logic             at_max;
  logic             at_zero;
  logic             upper_nz;
  logic             blank;
  logic [3:0]       cur_digit;
  logic [6:0]       seg_next;
  logic [DIGITS-1:0] an_next;

  assign tick    = en && (pcnt == PW'(PRESCALE - 1));
  assign at_max  = (count == MAX_BCD);
  assign at_zero = (count == '0);

  // A load is accepted only if every nibble is decimal and the value fits under the wrap value.
  // With all nibbles decimal, a plain unsigned compare of the BCD vectors orders them numerically.
  always_comb begin
    load_ok = (load_val <= MAX_BCD);
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  // Per-digit increment with decimal carry and decrement with decimal borrow.
  always_comb begin
    logic carry;
    logic borrow;
    inc_val = count;
    dec_val = count;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // Prescaler: runs only while enabled, cleared by a load or by its own terminal tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (load || tick) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Counter: load beats tick; tc and load_err are single-cycle registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tc       <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) count <= load_val;
        else         load_err <= 1'b1;
      end else if (tick) begin
        if (up) begin
          if (at_max) begin
            count <= '0;
            tc    <= 1'b1;
          end else begin
            count <= inc_val;
          end
        end else begin
          if (at_zero) begin
            count <= MAX_BCD;
            tc    <= 1'b1;
          end else begin
            count <= dec_val;
          end
        end
      end
    end
  end

  // Scan divider and digit index; independent of en and load.
  always_ff @(posedge clk) begin
    if (rst) begin
      scnt <= '0;
      idx  <= '0;
    end else if (scnt == SW'(REFRESH_DIV - 1)) begin
      scnt <= '0;
      idx  <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      scnt <= scnt + 1'b1;
    end
  end

  // Digit select and leading-zero blanking: a digit is blank when it and everything above it is zero.
  always_comb begin
    cur_digit = count[{idx, 2'b00} +: 4];
    upper_nz  = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if ((j >= int'(idx)) && (count[4*j +: 4] != 4'd0)) upper_nz = 1'b1;
    end
    blank    = BLANK_LZ && (idx != '0) && !upper_nz;
    seg_next = blank ? 7'b1111111 : glyph(cur_digit);
    an_next  = ~(DIGITS'(1) << idx);
  end

  // Registered display outputs, all dark during reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= 7'b1111111;
      an  <= '1;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_seg_bcd_counter_mux.sv
// Bench for seg_bcd_counter_mux: two instances (wrap 9999 with blanking, wrap 59 without) share stimulus.
// Reference model tracks the count as a plain integer and derives digits arithmetically.
// Directed steps followed by a randomized phase; every cycle compares all outputs of both instances.
module tb_seg_bcd_counter_mux;

  localparam int PRESCALE = 4;
  localparam int REFRESH  = 2;

  logic        clk = 1'b0;
  logic        rst, en, up, load;
  logic [15:0] load_val;
  logic [15:0] count_a, count_b;
  logic        tc_a, tc_b, err_a, err_b;
  logic [6:0]  seg_a, seg_b;
  logic [3:0]  an_a, an_b;

  always #5 clk = ~clk;

  seg_bcd_counter_mux #(.PRESCALE(PRESCALE), .REFRESH_DIV(REFRESH), .DIGITS(4),
                        .MAX_VALUE(9999), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count_a), .tc(tc_a), .load_err(err_a), .seg(seg_a), .an(an_a));

  seg_bcd_counter_mux #(.PRESCALE(PRESCALE), .REFRESH_DIV(REFRESH), .DIGITS(4),
                        .MAX_VALUE(59), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count_b), .tc(tc_b), .load_err(err_b), .seg(seg_b), .an(an_b));

  int passes = 0;
  int total  = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  int         maxv [2] = '{9999, 59};
  bit         blk  [2] = '{1'b1, 1'b0};
  int         m_val[2];
  int         m_p  [2];
  logic       m_tc [2];
  logic       m_err[2];
  logic [6:0] m_seg[2];
  logic [3:0] m_an;
  int         m_scnt, m_idx;
  logic [6:0] segtab[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b;
    for (int i = 0; i < 4; i++) b[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock edge of the reference behaviour, using the inputs currently applied.
  task automatic model_step();
    int  num, place;
    bit  ok, tick;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_val[k] = 0; m_p[k] = 0; m_tc[k] = 0; m_err[k] = 0; m_seg[k] = 7'b1111111;
      end
      m_an = 4'hF; m_scnt = 0; m_idx = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (blk[k] && m_idx > 0 && m_val[k] < pow10(m_idx)) m_seg[k] = 7'b1111111;
        else m_seg[k] = segtab[(m_val[k] / pow10(m_idx)) % 10];
      end
      m_an = ~(4'b0001 << m_idx);
      if (m_scnt == REFRESH - 1) begin
        m_scnt = 0;
        m_idx  = (m_idx + 1) % 4;
      end else begin
        m_scnt++;
      end
      ok = 1'b1; num = 0; place = 1;
      for (int i = 0; i < 4; i++) begin
        if (load_val[4*i +: 4] > 4'd9) ok = 1'b0;
        num += int'(load_val[4*i +: 4]) * place;
        place *= 10;
      end
      for (int k = 0; k < 2; k++) begin
        tick = en && (m_p[k] == PRESCALE - 1);
        m_tc[k] = 0; m_err[k] = 0;
        if (load) begin
          m_p[k] = 0;
          if (ok && num <= maxv[k]) m_val[k] = num;
          else m_err[k] = 1;
        end else if (en) begin
          if (tick) begin
            m_p[k] = 0;
            if (up) begin
              if (m_val[k] == maxv[k]) begin m_val[k] = 0; m_tc[k] = 1; end
              else m_val[k]++;
            end else begin
              if (m_val[k] == 0) begin m_val[k] = maxv[k]; m_tc[k] = 1; end
              else m_val[k]--;
            end
          end else begin
            m_p[k]++;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("a_count", count_a, to_bcd(m_val[0]));
    chk("a_tc",    tc_a,    m_tc[0]);
    chk("a_err",   err_a,   m_err[0]);
    chk("a_seg",   seg_a,   m_seg[0]);
    chk("a_an",    an_a,    m_an);
    chk("b_count", count_b, to_bcd(m_val[1]));
    chk("b_tc",    tc_b,    m_tc[1]);
    chk("b_err",   err_b,   m_err[1]);
    chk("b_seg",   seg_b,   m_seg[1]);
    chk("b_an",    an_b,    m_an);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_val = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 16'h0;
    step(); step();
    chk("reset_count", count_a, 16'h0000);
    chk("reset_seg",   seg_a,   7'b1111111);
    chk("reset_an",    an_a,    4'b1111);

    // Free-running count up: one tick every 4 cycles.
    rst = 1'b0; en = 1'b1; up = 1'b1;
    repeat (40) step();
    chk("count_at_40", count_a, 16'h0010);

    // Wrap up from 9999.
    do_load(16'h9998);
    repeat (4) step();
    chk("reach_9999", count_a, 16'h9999);
    repeat (4) step();
    chk("wrap_zero", count_a, 16'h0000);
    chk("wrap_tc", tc_a, 1'b1);
    step();
    chk("tc_one_cycle", tc_a, 1'b0);

    // Wrap down to 59 on the small instance; over-range load rejected.
    up = 1'b0;
    do_load(16'h0000);
    repeat (4) step();
    chk("b_wrap_59", count_b, 16'h0059);
    chk("b_wrap_tc", tc_b, 1'b1);
    do_load(16'h0060);
    chk("b_load_err", err_b, 1'b1);
    chk("b_hold_59", count_b, 16'h0059);

    // Decimal borrow and non-BCD load rejection.
    do_load(16'h0199);
    repeat (4) step();
    chk("borrow_0198", count_a, 16'h0198);
    do_load(16'h0200);
    repeat (4) step();
    chk("borrow_0199", count_a, 16'h0199);
    do_load(16'h12A4);
    chk("nonbcd_err", err_a, 1'b1);
    chk("nonbcd_hold", count_a, 16'h0199);

    // Frozen counter while the display scans 0042.
    en = 1'b0;
    do_load(16'h0042);
    repeat (20) step();
    chk("frozen_0042", count_a, 16'h0042);

    // Load coinciding with a tick: load wins.
    en = 1'b1; up = 1'b1;
    do_load(16'h0042);
    repeat (3) step();
    do_load(16'h0500);
    chk("load_beats_tick", count_a, 16'h0500);
    repeat (3) step();
    chk("no_late_tick", count_a, 16'h0500);

    // Randomized phase.
    for (int n = 0; n < 400; n++) begin
      rst  = ($urandom_range(99, 0) == 0);
      en   = ($urandom_range(3, 0) != 0);
      up   = 1'($urandom_range(1, 0));
      load = ($urandom_range(15, 0) == 0);
      if ($urandom_range(1, 0) == 1) load_val = to_bcd($urandom_range(9999, 0));
      else if ($urandom_range(1, 0) == 1) load_val = to_bcd($urandom_range(99, 0));
      else load_val = 16'($urandom);
      step();
    end

    // Reset overrides a simultaneous load.
    rst = 1'b1; load = 1'b1; load_val = 16'h1234; en = 1'b1;
    step();
    chk("rst_load_count", count_a, 16'h0000);
    chk("rst_load_seg",   seg_a,   7'b1111111);
    chk("rst_load_an",    an_a,    4'b1111);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
